// File: rtl/uart_frame_pkg.sv
// Shared framing definitions for the UART frame receiver and transmitter.
// The checksum is a mod-256 sum of LEN and the payload bytes; SYNC is excluded.
package uart_frame_pkg;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_LEN     = 3'd1;
  localparam logic [2:0] ST_PAYLOAD = 3'd2;
  localparam logic [2:0] ST_CHK     = 3'd3;
  localparam logic [2:0] ST_SEND    = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE    = ST_IDLE,
    S_LEN     = ST_LEN,
    S_PAYLOAD = ST_PAYLOAD,
    S_CHK     = ST_CHK,
    S_SEND    = ST_SEND
  } state_e;

  function automatic logic [7:0] chk_add(input logic [7:0] sum, input logic [7:0] b);
    return sum + b;
  endfunction

endpackage

// File: rtl/uart_frame_rx.sv
// Assembles SYNC/LEN/payload/CHK frames from a byte strobe, buffers validated
// payloads and drains them on a ready/valid byte stream.
module uart_frame_rx
  import uart_frame_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT,
  parameter int         MAX_LEN        = 16,
  parameter int         TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       frame_ok,
  output logic       err_len,
  output logic       err_chk,
  output logic       err_timeout,
  output logic       drop
);

  localparam int IW = $clog2(MAX_LEN + 1);
  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);

  state_e        state_q, state_d;
  logic [IW-1:0] len_q, len_d;
  logic [IW-1:0] wr_idx_q, wr_idx_d;
  logic [IW-1:0] rd_idx_q, rd_idx_d;
  logic [7:0]    sum_q, sum_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          out_valid_q, out_valid_d;
  logic          frame_ok_q, frame_ok_d;
  logic          err_len_q, err_len_d;
  logic          err_chk_q, err_chk_d;
  logic          err_timeout_q, err_timeout_d;
  logic          drop_q, drop_d;
  logic          buf_we;
  logic          rd_last;
  logic [7:0]    pbuf_q [MAX_LEN];

  assign rd_last     = (rd_idx_q == len_q - IW'(1));
  // Gate on valid so the undefined buffer never leaks out after reset.
  assign out_data    = out_valid_q ? pbuf_q[rd_idx_q[AW-1:0]] : 8'h00;
  assign out_last    = out_valid_q && rd_last;
  assign out_valid   = out_valid_q;
  assign frame_ok    = frame_ok_q;
  assign err_len     = err_len_q;
  assign err_chk     = err_chk_q;
  assign err_timeout = err_timeout_q;
  assign drop        = drop_q;

  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    wr_idx_d      = wr_idx_q;
    rd_idx_d      = rd_idx_q;
    sum_d         = sum_q;
    tmo_d         = tmo_q;
    out_valid_d   = out_valid_q;
    frame_ok_d    = 1'b0;
    err_len_d     = 1'b0;
    err_chk_d     = 1'b0;
    err_timeout_d = 1'b0;
    drop_d        = 1'b0;
    buf_we        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rx_valid && rx_data == SYNC_BYTE) begin
          state_d = S_LEN;
          tmo_d   = '0;
        end
      end
      S_LEN, S_PAYLOAD, S_CHK: begin
        if (!rx_valid) begin
          if (tmo_q == TO_LAST) begin
            err_timeout_d = 1'b1;
            state_d       = S_IDLE;
            tmo_d         = '0;
          end else begin
            tmo_d = tmo_q + TW'(1);
          end
        end else begin
          tmo_d = '0;
          case (state_q)
            S_LEN: begin
              if (rx_data != 8'd0 && rx_data <= MAX_LEN_B) begin
                len_d    = rx_data[IW-1:0];
                sum_d    = rx_data;
                wr_idx_d = '0;
                state_d  = S_PAYLOAD;
              end else begin
                err_len_d = 1'b1;
                state_d   = S_IDLE;
              end
            end
            S_PAYLOAD: begin
              buf_we   = 1'b1;
              wr_idx_d = wr_idx_q + IW'(1);
              sum_d    = chk_add(sum_q, rx_data);
              if (wr_idx_q == len_q - IW'(1)) state_d = S_CHK;
            end
            default: begin
              if (rx_data == sum_q) begin
                frame_ok_d  = 1'b1;
                rd_idx_d    = '0;
                out_valid_d = 1'b1;
                state_d     = S_SEND;
              end else begin
                err_chk_d = 1'b1;
                state_d   = S_IDLE;
              end
            end
          endcase
        end
      end
      S_SEND: begin
        // Bytes arriving while draining are lost, never parsed as SYNC.
        if (rx_valid) drop_d = 1'b1;
        if (out_ready) begin
          if (rd_last) begin
            out_valid_d = 1'b0;
            rd_idx_d    = '0;
            state_d     = S_IDLE;
          end else begin
            rd_idx_d = rd_idx_q + IW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      len_q         <= '0;
      wr_idx_q      <= '0;
      rd_idx_q      <= '0;
      sum_q         <= '0;
      tmo_q         <= '0;
      out_valid_q   <= 1'b0;
      frame_ok_q    <= 1'b0;
      err_len_q     <= 1'b0;
      err_chk_q     <= 1'b0;
      err_timeout_q <= 1'b0;
      drop_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      wr_idx_q      <= wr_idx_d;
      rd_idx_q      <= rd_idx_d;
      sum_q         <= sum_d;
      tmo_q         <= tmo_d;
      out_valid_q   <= out_valid_d;
      frame_ok_q    <= frame_ok_d;
      err_len_q     <= err_len_d;
      err_chk_q     <= err_chk_d;
      err_timeout_q <= err_timeout_d;
      drop_q        <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (buf_we) pbuf_q[wr_idx_q[AW-1:0]] <= rx_data;
  end

endmodule

// File: tb/tb_uart_frame_rx.sv
// Directed bench for uart_frame_rx: each task drives one scenario and checks inline.
module tb_uart_frame_rx;

  localparam int TMO = 20;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_last;
  logic       frame_ok;
  logic       err_len;
  logic       err_chk;
  logic       err_timeout;
  logic       drop;

  int checks = 0;
  int errors = 0;

  int n_ok = 0, n_len = 0, n_chk = 0, n_tmo = 0, n_drop = 0, n_vld = 0;
  int cyc = 0;
  logic [8:0] rx_q [$];
  int         hs_cyc [$];

  uart_frame_rx #(
    .SYNC_BYTE(8'hA5),
    .MAX_LEN(16),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last(out_last),
    .frame_ok(frame_ok),
    .err_len(err_len),
    .err_chk(err_chk),
    .err_timeout(err_timeout),
    .drop(drop)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (frame_ok)    n_ok++;
    if (err_len)     n_len++;
    if (err_chk)     n_chk++;
    if (err_timeout) n_tmo++;
    if (drop)        n_drop++;
    if (out_valid)   n_vld++;
    if (out_valid && out_ready) begin
      rx_q.push_back({out_last, out_data});
      hs_cyc.push_back(cyc);
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; out_ready = 1'b1;
    idle(3);
    checks++; if (out_valid !== 1'b0)   begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (out_data !== 8'h00)   begin errors++; $display("FAIL reset_out_data got %h want 00", out_data); end
    checks++; if (out_last !== 1'b0)    begin errors++; $display("FAIL reset_out_last got %b want 0", out_last); end
    checks++; if ({frame_ok, err_len, err_chk, err_timeout, drop} !== 5'b0)
      begin errors++; $display("FAIL reset_pulses got %b want 00000", {frame_ok, err_len, err_chk, err_timeout, drop}); end
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_good_frame;
    int b0 = rx_q.size();
    int k0 = n_ok;
    logic [8:0] exp [3];
    exp = '{9'h011, 9'h022, 9'h133};
    out_ready = 1'b1;
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    send_byte(8'h69);
    checks++; if (frame_ok !== 1'b1)  begin errors++; $display("FAIL good_frame_ok got %b want 1", frame_ok); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL good_valid_rise got %b want 1", out_valid); end
    checks++; if (out_data !== 8'h11) begin errors++; $display("FAIL good_first_data got %h want 11", out_data); end
    idle(5);
    checks++;
    if (rx_q.size() - b0 != 3) begin
      errors++; $display("FAIL good_count got %0d want 3", rx_q.size() - b0);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (rx_q[b0+i] !== exp[i]) begin errors++; $display("FAIL good_byte%0d got %h want %h", i, rx_q[b0+i], exp[i]); end
      end
      checks++;
      if (hs_cyc[b0+2] - hs_cyc[b0] != 2) begin errors++; $display("FAIL good_consecutive got %0d want 2", hs_cyc[b0+2] - hs_cyc[b0]); end
    end
    checks++; if (n_ok - k0 != 1)     begin errors++; $display("FAIL good_ok_count got %0d want 1", n_ok - k0); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL good_back_idle got %b want 0", out_valid); end
  endtask

  task automatic test_bad_chk;
    int b0 = rx_q.size();
    int v0 = n_vld;
    int c0 = n_chk;
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    send_byte(8'h68);
    checks++; if (err_chk !== 1'b1) begin errors++; $display("FAIL badchk_pulse got %b want 1", err_chk); end
    idle(3);
    checks++; if (n_vld != v0)      begin errors++; $display("FAIL badchk_no_valid got %0d want %0d", n_vld, v0); end
    checks++; if (n_chk - c0 != 1)  begin errors++; $display("FAIL badchk_count got %0d want 1", n_chk - c0); end
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h10); send_byte(8'h11);
    idle(3);
    checks++;
    if (rx_q.size() - b0 != 1) begin errors++; $display("FAIL badchk_recover_count got %0d want 1", rx_q.size() - b0); end
    else if (rx_q[b0] !== 9'h110) begin errors++; $display("FAIL badchk_recover_byte got %h want 110", rx_q[b0]); end
  endtask

  task automatic test_bad_len;
    int b0 = rx_q.size();
    int l0 = n_len;
    int v0 = n_vld;
    int e0 = n_chk + n_tmo + n_drop;
    send_byte(8'hA5); send_byte(8'h00);
    checks++; if (err_len !== 1'b1) begin errors++; $display("FAIL badlen_zero got %b want 1", err_len); end
    send_byte(8'hA5); send_byte(8'h11);
    checks++; if (err_len !== 1'b1) begin errors++; $display("FAIL badlen_17 got %b want 1", err_len); end
    send_byte(8'h3C); send_byte(8'h7E);
    idle(4);
    checks++; if (n_len - l0 != 2) begin errors++; $display("FAIL badlen_count got %0d want 2", n_len - l0); end
    checks++; if (n_vld != v0 || rx_q.size() != b0) begin errors++; $display("FAIL badlen_no_output got %0d want 0", n_vld - v0); end
    checks++; if (n_chk + n_tmo + n_drop != e0) begin errors++; $display("FAIL noise_flagged got %0d want 0", n_chk + n_tmo + n_drop - e0); end
  endtask

  task automatic test_timeout;
    int b0 = rx_q.size();
    int t0 = n_tmo;
    int first = -1;
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h44);
    for (int k = 1; k <= TMO + 10; k++) begin
      @(posedge clk); #1;
      if (err_timeout && first < 0) first = k;
    end
    checks++; if (first != TMO)     begin errors++; $display("FAIL timeout_cycle got %0d want %0d", first, TMO); end
    checks++; if (n_tmo - t0 != 1)  begin errors++; $display("FAIL timeout_once got %0d want 1", n_tmo - t0); end
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h55); send_byte(8'h56);
    idle(3);
    checks++;
    if (rx_q.size() - b0 != 1) begin errors++; $display("FAIL timeout_recover_count got %0d want 1", rx_q.size() - b0); end
    else if (rx_q[b0] !== 9'h155) begin errors++; $display("FAIL timeout_recover_byte got %h want 155", rx_q[b0]); end
  endtask

  task automatic test_backpressure;
    int b0 = rx_q.size();
    int d0 = n_drop;
    out_ready = 1'b0;
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'hAA); send_byte(8'hBB); send_byte(8'h67);
    checks++; if (out_valid !== 1'b1 || out_data !== 8'hAA) begin errors++; $display("FAIL bp_first got %b/%h want 1/aa", out_valid, out_data); end
    send_byte(8'hA5);
    checks++; if (drop !== 1'b1) begin errors++; $display("FAIL bp_drop_pulse got %b want 1", drop); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'hAA || out_last !== 1'b0) begin
        errors++; $display("FAIL bp_hold%0d got %b/%h/%b want 1/aa/0", i, out_valid, out_data, out_last);
      end
      idle(1);
    end
    out_ready = 1'b1;
    idle(4);
    checks++;
    if (rx_q.size() - b0 != 2) begin errors++; $display("FAIL bp_count got %0d want 2", rx_q.size() - b0); end
    else if (rx_q[b0] !== 9'h0AA || rx_q[b0+1] !== 9'h1BB) begin
      errors++; $display("FAIL bp_order got %h %h want 0aa 1bb", rx_q[b0], rx_q[b0+1]);
    end
    checks++; if (n_drop - d0 != 1) begin errors++; $display("FAIL bp_drop_count got %0d want 1", n_drop - d0); end
  endtask

  task automatic test_back_to_back;
    int b0 = rx_q.size();
    out_ready = 1'b1;
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h77); send_byte(8'h78);
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h66); send_byte(8'h67);
    idle(3);
    checks++;
    if (rx_q.size() - b0 != 2) begin errors++; $display("FAIL b2b_count got %0d want 2", rx_q.size() - b0); end
    else if (rx_q[b0] !== 9'h177 || rx_q[b0+1] !== 9'h166) begin
      errors++; $display("FAIL b2b_data got %h %h want 177 166", rx_q[b0], rx_q[b0+1]);
    end
  endtask

  task automatic test_reset_mid;
    int b0 = rx_q.size();
    send_byte(8'hA5); send_byte(8'h04); send_byte(8'h01); send_byte(8'h02);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    out_ready = 1'b0;
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h10); send_byte(8'h11);
    checks++; if (out_valid !== 1'b1 || out_data !== 8'h10) begin errors++; $display("FAIL rstmid_payload got %b/%h want 1/10", out_valid, out_data); end
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || out_data !== 8'h00 || out_last !== 1'b0) begin
      errors++; $display("FAIL rstmid_send_clear got %b/%h/%b want 0/00/0", out_valid, out_data, out_last);
    end
    idle(1);
    rst = 1'b0;
    out_ready = 1'b1;
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h10); send_byte(8'h11);
    idle(3);
    checks++;
    if (rx_q.size() - b0 != 1) begin errors++; $display("FAIL rstmid_count got %0d want 1", rx_q.size() - b0); end
    else if (rx_q[b0] !== 9'h110) begin errors++; $display("FAIL rstmid_byte got %h want 110", rx_q[b0]); end
  endtask

  initial begin
    rst = 1'b1;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    out_ready = 1'b1;
    test_reset();
    test_good_frame();
    test_bad_chk();
    test_bad_len();
    test_timeout();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
